// File: rtl/thread_state_scanner_pkg.sv
// Shared thread-state encodings and scanner FSM states for the sha256 thread-state scanner.
package thread_state_scanner_pkg;

    localparam int THREAD_STATE_MSB = 1;

    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_NONE   = 2'd0;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_RD_RDY = 2'd1;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_BUSY   = 2'd2;
    localparam logic [THREAD_STATE_MSB:0] THREAD_STATE_WR_RDY = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_CLAIM = 3'd3,
        ST_OFFER = 3'd4
    } scan_state_e;

endpackage

// File: rtl/thread_state_scanner.sv
// Round-robin scanner over the per-thread state memory: finds a MATCH_STATE thread,
// claims it with a single write and offers its number over a valid/ready handshake.
module thread_state_scanner
    import thread_state_scanner_pkg::*;
#(
    parameter int                          N_THREADS     = 6,
    parameter int                          N_THREADS_MSB = $clog2(N_THREADS) - 1,
    parameter logic [THREAD_STATE_MSB:0]   MATCH_STATE   = THREAD_STATE_RD_RDY,
    parameter logic [THREAD_STATE_MSB:0]   CLAIM_STATE   = THREAD_STATE_BUSY
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          en,
    output logic [N_THREADS_MSB:0]        rd_num,
    input  logic [THREAD_STATE_MSB:0]     rd_state,
    output logic                          wr_en,
    output logic [N_THREADS_MSB:0]        wr_num,
    output logic [THREAD_STATE_MSB:0]     wr_state,
    output logic                          thread_valid,
    output logic [N_THREADS_MSB:0]        thread_num,
    input  logic                          thread_ready,
    output logic                          err
);

    localparam int                     PTR_W     = N_THREADS_MSB + 1;
    localparam logic [N_THREADS_MSB:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [N_THREADS_MSB:0] PTR_ONE   = PTR_W'(1);
    localparam logic [N_THREADS_MSB:0] PTR_LAST  = PTR_W'(N_THREADS - 1);
    localparam logic [THREAD_STATE_MSB:0] STATE_ZERO = {(THREAD_STATE_MSB + 1){1'b0}};

    // Wraps at N_THREADS-1 so unused encodings never reach the read port.
    function automatic logic [N_THREADS_MSB:0] ptr_inc(input logic [N_THREADS_MSB:0] p);
        logic [N_THREADS_MSB:0] r;
        if (p >= PTR_LAST) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    scan_state_e                  state_r, state_s;
    logic [N_THREADS_MSB:0]       ptr_r, ptr_s;
    logic [N_THREADS_MSB:0]       rd_num_s, wr_num_s, thread_num_s;
    logic [THREAD_STATE_MSB:0]    wr_state_s;
    logic                         wr_en_s, thread_valid_s, err_s;

    // Next-state, pointer and next-output logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: state_s = ST_CHECK;
            ST_CHECK: begin
                if (!en) begin
                    state_s = ST_IDLE;
                end else if (rd_state == MATCH_STATE) begin
                    state_s = ST_CLAIM;
                end else begin
                    ptr_s   = ptr_inc(ptr_r);
                    state_s = ST_READ;
                end
            end
            ST_CLAIM: state_s = ST_OFFER;
            ST_OFFER: begin
                if (thread_valid && thread_ready) begin
                    ptr_s   = ptr_inc(ptr_r);
                    state_s = en ? ST_READ : ST_IDLE;
                end else begin
                    state_s = ST_OFFER;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Outputs are loaded on entry to the state that presents them.
        if (state_s == ST_READ) begin
            rd_num_s = ptr_s;
        end else begin
            rd_num_s = rd_num;
        end
        wr_en_s = (state_s == ST_CLAIM);
        if (wr_en_s) begin
            wr_num_s   = ptr_s;
            wr_state_s = CLAIM_STATE;
        end else begin
            wr_num_s   = wr_num;
            wr_state_s = STATE_ZERO;
        end
        thread_valid_s = (state_s == ST_OFFER);
        if (state_r == ST_CLAIM) begin
            thread_num_s = ptr_r;
        end else begin
            thread_num_s = thread_num;
        end
        err_s = err | (thread_ready & ~thread_valid);
    end

    // State, pointer and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            ptr_r        <= PTR_ZERO;
            rd_num       <= PTR_ZERO;
            wr_en        <= 1'b0;
            wr_num       <= PTR_ZERO;
            wr_state     <= STATE_ZERO;
            thread_valid <= 1'b0;
            thread_num   <= PTR_ZERO;
            err          <= 1'b0;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            rd_num       <= rd_num_s;
            wr_en        <= wr_en_s;
            wr_num       <= wr_num_s;
            wr_state     <= wr_state_s;
            thread_valid <= thread_valid_s;
            thread_num   <= thread_num_s;
            err          <= err_s;
        end
    end

endmodule
